// File: rtl/fp_mul_pkg.sv
// rtl/fp_mul_pkg.sv - shared FSM state, format defaults and IEEE constant helpers for fp_mul_seq
package fp_mul_pkg;

    typedef enum logic [1:0] {IDLE, MULT, NORM, DONE} state_t;

    localparam int DEF_EW = 8;
    localparam int DEF_MW = 23;

    function automatic int fp_bias(input int ew);
        return (1 << (ew - 1)) - 1;
    endfunction

    // Canonical quiet NaN: positive, all-ones exponent, mantissa MSB only.
    function automatic logic [63:0] fp_qnan(input int ew, input int mw);
        logic [63:0] exp_ones;
        exp_ones = (64'd1 << ew) - 64'd1;
        return (exp_ones << mw) | (64'd1 << (mw - 1));
    endfunction

    function automatic logic [63:0] fp_inf(input logic sign, input int ew, input int mw);
        logic [63:0] exp_ones;
        exp_ones = (64'd1 << ew) - 64'd1;
        return ({63'd0, sign} << (ew + mw)) | (exp_ones << mw);
    endfunction

endpackage

// File: rtl/fp_booth_r4_seq.sv
// rtl/fp_booth_r4_seq.sv - sequential radix-4 Booth multiplier for unsigned M-bit operands
module fp_booth_r4_seq #(
    parameter int M = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [M-1:0]     mcand_i,
    input  logic [M-1:0]     mplr_i,
    output logic             done_o,
    output logic [2*M-1:0]   prod_o
);
    localparam int N  = (M + 1) / 2;
    localparam int PW = 2 * M;
    localparam int CW = $clog2(N + 1);

    logic [PW-1:0]  mcand_q, acc_q, acc_init, pp;
    logic [2*N:0]   mplr_q;
    logic [CW-1:0]  cnt_q;
    logic           busy_q, done_q;
    logic [2*N-1:0] x_ext;

    always_comb begin
        x_ext = '0;
        x_ext[M-1:0] = mplr_i;
        // Booth reads the top digit as signed; pre-loading mcand<<2N restores the unsigned value.
        acc_init = '0;
        if (x_ext[2*N-1])
            acc_init = PW'(mcand_i) << (2 * N);
        unique case (mplr_q[2:0])
            3'b001, 3'b010: pp = mcand_q;
            3'b011:         pp = mcand_q << 1;
            3'b100:         pp = -(mcand_q << 1);
            3'b101, 3'b110: pp = -mcand_q;
            default:        pp = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q <= '0;
            acc_q   <= '0;
            mplr_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                mcand_q <= PW'(mcand_i);
                mplr_q  <= {x_ext, 1'b0};
                acc_q   <= acc_init;
                cnt_q   <= CW'(N);
                busy_q  <= 1'b1;
            end else if (busy_q) begin
                acc_q   <= acc_q + pp;
                mcand_q <= mcand_q << 2;
                mplr_q  <= mplr_q >> 2;
                cnt_q   <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done_o = done_q;
    assign prod_o = acc_q;

endmodule

// File: rtl/fp_mul_seq.sv
// rtl/fp_mul_seq.sv - sequential IEEE-style multiplier; FP_MUL_SEQ_ROUND_EN selects RNE over truncation
module fp_mul_seq
    import fp_mul_pkg::*;
#(
    parameter  int EW = DEF_EW,
    parameter  int MW = DEF_MW,
    localparam int W  = 1 + EW + MW
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic [3:0]   flags
);
    localparam int M  = MW + 1;
    localparam int PW = 2 * M;
    localparam int XW = EW + 2;
    localparam logic [W-1:0]         QNAN = W'(fp_qnan(EW, MW));
    localparam logic signed [XW-1:0] BIAS = XW'(fp_bias(EW));
    localparam logic signed [XW-1:0] EMAX = XW'((1 << EW) - 1);
    localparam logic signed [XW-1:0] ZERO = '0;

    state_t        state_q;
    logic          in_ready_q, out_valid_q;
    logic [W-1:0]  a_q, b_q, y_q, y_d;
    logic [3:0]    flags_q, flags_d;
    logic          mul_start, mul_done;
    logic [PW-1:0] prod;

    assign mul_start = (state_q == IDLE) && in_valid;

    fp_booth_r4_seq #(.M(M)) u_booth (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (mul_start),
        .mcand_i ({1'b1, a[MW-1:0]}),
        .mplr_i  ({1'b1, b[MW-1:0]}),
        .done_o  (mul_done),
        .prod_o  (prod)
    );

    logic [EW-1:0] ea, eb;
    logic [MW-1:0] ma, mb, man, man_r;
    logic          sy, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, guard, sticky;
    logic [PW-2:0] norm;
    logic signed [XW-1:0] e;
`ifdef FP_MUL_SEQ_ROUND_EN
    logic          carry;
`endif

    assign ea     = a_q[W-2 -: EW];
    assign eb     = b_q[W-2 -: EW];
    assign ma     = a_q[MW-1:0];
    assign mb     = b_q[MW-1:0];
    assign sy     = a_q[W-1] ^ b_q[W-1];
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == '1) && (ma == '0);
    assign b_inf  = (eb == '1) && (mb == '0);
    assign a_nan  = (ea == '1) && (ma != '0);
    assign b_nan  = (eb == '1) && (mb != '0);

    always_comb begin
        norm   = prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
        man    = norm[PW-2 -: MW];
        guard  = norm[MW];
        sticky = |norm[MW-1:0];
        e      = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS
               + $signed({{(XW-1){1'b0}}, prod[PW-1]});
`ifdef FP_MUL_SEQ_ROUND_EN
        {carry, man_r} = {1'b0, man} + {{MW{1'b0}}, guard & (sticky | man[0])};
        if (carry)
            e = e + XW'(1);
`else
        man_r = man;
`endif
        y_d     = '0;
        flags_d = '0;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            y_d        = QNAN;
            flags_d[3] = (a_inf && b_zero) || (b_inf && a_zero);
        end else if (a_inf || b_inf) begin
            y_d = W'(fp_inf(sy, EW, MW));
        end else if (a_zero || b_zero) begin
            y_d = {sy, {(W-1){1'b0}}};
        end else if (e >= EMAX) begin
            y_d     = W'(fp_inf(sy, EW, MW));
            flags_d = 4'b0101;
        end else if (e <= ZERO) begin
            y_d     = {sy, {(W-1){1'b0}}};
            flags_d = 4'b0011;
        end else begin
            y_d        = {sy, e[EW-1:0], man_r};
            flags_d[0] = guard | sticky;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            y_q         <= '0;
            flags_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (in_valid) begin
                    a_q        <= a;
                    b_q        <= b;
                    in_ready_q <= 1'b0;
                    state_q    <= MULT;
                end
                MULT: if (mul_done) state_q <= NORM;
                NORM: begin
                    y_q         <= y_d;
                    flags_q     <= flags_d;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// tb/tb_fp_mul_seq.sv - randomized and directed self-checking bench for fp_mul_seq
`timescale 1ns/1ps
module tb_fp_mul_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] a = '0, b = '0;
    logic        in_ready, out_valid;
    logic [31:0] y;
    logic [3:0]  flags;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_mode = 0;
    int wait_cnt = 0;
    logic [35:0] exp_q[$];
    int          acc_q[$];
    logic [35:0] e0;
    logic [31:0] held_y;
    logic [3:0]  held_f;
    logic [31:0] da[8], db[8];
    logic [35:0] dexp[8];

    fp_mul_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .flags(flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference: exact integer product, then remainder-vs-half rounding decision.
    function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] z);
        int ex, ez, e, sh;
        longint unsigned mx, mz, p, keep, rem, half;
        logic s, xzero, zzero, xinf, zinf, xnan, znan;
        ex = int'(x[30:23]);
        ez = int'(z[30:23]);
        mx = longint'(x[22:0]);
        mz = longint'(z[22:0]);
        s  = x[31] ^ z[31];
        xzero = (ex == 0);
        zzero = (ez == 0);
        xinf  = (ex == 255) && (mx == 0);
        zinf  = (ez == 255) && (mz == 0);
        xnan  = (ex == 255) && (mx != 0);
        znan  = (ez == 255) && (mz != 0);
        if (xnan || znan) return {4'b0000, 32'h7FC00000};
        if ((xinf && zzero) || (zinf && xzero)) return {4'b1000, 32'h7FC00000};
        if (xinf || zinf) return {4'b0000, s, 8'hFF, 23'h0};
        if (xzero || zzero) return {4'b0000, s, 31'h0};
        p    = (mx + 64'h800000) * (mz + 64'h800000);
        sh   = (p >= (64'd1 << 47)) ? 1 : 0;
        e    = ex + ez - 127 + sh;
        keep = p >> (23 + sh);
        rem  = p - (keep << (23 + sh));
        half = 64'd1 << (22 + sh);
`ifdef FP_MUL_SEQ_ROUND_EN
        if (rem > half || (rem == half && keep[0])) keep = keep + 1;
        if (keep == (64'd1 << 24)) begin
            keep = keep >> 1;
            e = e + 1;
        end
`endif
        if (e >= 255) return {4'b0101, s, 8'hFF, 23'h0};
        if (e <= 0) return {4'b0011, s, 31'h0};
        return {3'b000, rem != 0, s, e[7:0], keep[22:0]};
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [31:0] r;
        int sel;
        r   = $urandom;
        sel = $urandom_range(0, 15);
        case (sel)
            0:  r[30:23] = 8'h00;
            1:  begin r[30:23] = 8'hFF; r[22:0] = '0; end
            2:  r[30:23] = 8'hFF;
            3, 4, 5, 6, 7, 8, 9: r[30:23] = 8'($urandom_range(64, 190));
            10, 11: begin r[30:23] = 8'($urandom_range(100, 154)); r[22:0] = 23'h7FFFFF; end
            12: r[30:23] = 8'($urandom_range(1, 10));
            default: ;
        endcase
        return r;
    endfunction

    task automatic send(input logic [31:0] x, input logic [31:0] z);
        int t;
        t = 0;
        @(negedge clk);
        a = x;
        b = z;
        in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stuck 0 for %0d cycles, required 1", t);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(model(x, z));
        acc_q.push_back(cyc + 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
            exp_q.delete();
            acc_q.delete();
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            wait_cnt = 0;
        end else if (out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_out_valid: out_valid=%0b with no pending operation, required 0", out_valid);
            end else begin
                e0 = exp_q[0];
                if (wait_cnt == 0) begin
                    check("latency", 64'(cyc - acc_q[0]), 64'd14);
                    check("y", 64'(y), 64'(e0[31:0]));
                    check("flags", 64'(flags), 64'(e0[35:32]));
                    held_y = y;
                    held_f = flags;
                end else begin
                    check("y_stable", 64'(y), 64'(held_y));
                    check("flags_stable", 64'(flags), 64'(held_f));
                end
                check("in_ready_in_done", 64'(in_ready), 64'd0);
                wait_cnt++;
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    void'(acc_q.pop_front());
                    wait_cnt = 0;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #2;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = (wait_cnt >= 5);
        endcase
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int viol;
        da[0] = 32'h40000000; db[0] = 32'h40400000; dexp[0] = {4'h0, 32'h40C00000};
`ifdef FP_MUL_SEQ_ROUND_EN
        da[1] = 32'h3F800001; db[1] = 32'h3FC00000; dexp[1] = {4'h1, 32'h3FC00002};
`else
        da[1] = 32'h3F800001; db[1] = 32'h3FC00000; dexp[1] = {4'h1, 32'h3FC00001};
`endif
        da[2] = 32'h7F800000; db[2] = 32'h00000000; dexp[2] = {4'h8, 32'h7FC00000};
        da[3] = 32'hFF800000; db[3] = 32'h40000000; dexp[3] = {4'h0, 32'hFF800000};
        da[4] = 32'h7F000000; db[4] = 32'h7F000000; dexp[4] = {4'h5, 32'h7F800000};
        da[5] = 32'h00800000; db[5] = 32'h00800000; dexp[5] = {4'h3, 32'h00000000};
        da[6] = 32'h80000000; db[6] = 32'h40400000; dexp[6] = {4'h0, 32'h80000000};
        da[7] = 32'h7FC00001; db[7] = 32'h3F800000; dexp[7] = {4'h0, 32'h7FC00000};

        for (int i = 0; i < 8; i++)
            check($sformatf("model_pin_%0d", i), 64'(model(da[i], db[i])), 64'(dexp[i]));

        repeat (3) @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_y", 64'(y), 64'd0);
        check("reset_flags", 64'(flags), 64'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        rdy_mode = 0;
        for (int i = 0; i < 8; i++) send(da[i], db[i]);
        drain();

        rdy_mode = 2;
        send(32'h40000000, 32'h40400000);
        send(32'h3F800001, 32'h3FC00000);
        drain();
        rdy_mode = 0;

        send(32'h7F000000, 32'h7F000000);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        exp_q.delete();
        acc_q.delete();
        #1;
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        viol = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) viol++;
        end
        check("abort_no_output", 64'(viol), 64'd0);
        send(32'h40000000, 32'h40400000);
        drain();

        rdy_mode = 1;
        repeat (300) send(rnd_op(), rnd_op());
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_mul_seq.md
FP_MUL_SEQ -- requirements
Module: fp_mul_seq

Interface
REQ-001 Parameter EW, default 8, exponent field width.
REQ-002 Parameter MW, default 23, stored mantissa field width; the operand width is W = 1+EW+MW.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  operand pair valid.
REQ-007 in_ready  output  1  block can accept operands.
REQ-008 a, b  input  W each  IEEE-754-style operands {sign, exp, man}.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 y  output  W  product.
REQ-012 flags  output  4  {invalid, overflow, underflow, inexact}.

Function
REQ-013 FSM states SHALL be IDLE, MULT, NORM and DONE.
REQ-014 In IDLE, in_ready=1 and in_valid=1 SHALL capture a and b and go to MULT; in all other states in_ready=0.
REQ-015 MULT SHALL run a sequential radix-4 Booth multiply of {1,man_a} x {1,man_b}, retiring 2 bits per cycle for N=ceil((MW+1)/2) cycles (12 at default), then go to NORM.
REQ-016 NORM SHALL normalise, round and pack in one cycle, then go to DONE.
REQ-017 DONE SHALL hold out_valid=1 and keep y and flags stable until out_ready=1, then go to IDLE; no new operand is accepted in that same cycle.
REQ-018 out_valid SHALL first assert N+2 cycles after the accept edge for every input class, including special cases.
REQ-019 sign = sign_a XOR sign_b for all non-NaN results.
REQ-020 Exponent arithmetic SHALL be signed, EW+2 bits: e = ea + eb - bias (+1 when product MSB is set), with bias = 2^(EW-1)-1.
REQ-021 Exp field 0 SHALL be treated as signed zero (subnormals flushed); all-ones exp with man=0 is Inf; all-ones exp with man!=0 is NaN.
REQ-022 NaN input, or Inf x 0, SHALL give canonical quiet NaN {0, all-ones, 1 followed by zeros}; Inf x 0 also sets invalid.
REQ-023 Inf x finite-nonzero SHALL give signed Inf with no flags; zero x finite SHALL give signed zero with no flags.
REQ-024 Biased e >= all-ones SHALL give signed Inf with overflow=1 and inexact=1.
REQ-025 Biased e <= 0 SHALL give signed zero with underflow=1 and inexact=1.
REQ-026 inexact SHALL be 1 whenever any discarded product bit is nonzero.

Reset
REQ-027 Reset SHALL force IDLE, in_ready=1, out_valid=0, y=0 and flags=0.
REQ-028 Reset asserted mid-MULT, mid-NORM or in DONE SHALL abort the operation with no output produced.

Configuration
REQ-029 Macro FP_MUL_SEQ_ROUND_EN.
  - Defined: round-to-nearest-even, using guard and sticky bits; a mantissa carry-out SHALL increment the exponent, with overflow re-checked after rounding.
  - Undefined: truncation toward zero; inexact is still reported.

Structure
REQ-030 Package fp_mul_pkg SHALL hold the FSM state enum, the default EW/MW values, the bias function, and the canonical-NaN/Inf constructors.
REQ-031 Sub-module fp_booth_r4_seq (start/done handshake, 2(MW+1)-bit product) SHALL implement the MULT datapath.

Verification
REQ-032 0x40000000 x 0x40400000 -> y=0x40C00000, flags=0, out_valid exactly 14 cycles after accept.
REQ-033 0x3F800001 x 0x3FC00000 -> with macro defined y=0x3FC00002; undefined y=0x3FC00001; inexact=1 in both cases.
REQ-034 0x7F800000 x 0x00000000 -> y=0x7FC00000 with invalid=1; 0xFF800000 x 0x40000000 -> y=0xFF800000 with flags=0.
REQ-035 0x7F000000 x 0x7F000000 -> y=0x7F800000 with overflow=1 and inexact=1; 0x00800000 x 0x00800000 -> y=0x00000000 with underflow=1.
REQ-036 Hold out_ready=0 for 5 cycles in DONE -> y stable and in_ready=0; rst_n pulsed low in cycle 6 of MULT -> out_valid stays 0 and the next operation is correct.
